// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Word-granular 64-bit memory behind a byte address.
package dmem_pkg;
  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 64;
  localparam int WORD_SHIFT = 3;
  localparam int IDX_W      = ADDR_W - WORD_SHIFT;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Misaligned or beyond the last word: answered with err, never touches the array.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a, input int unsigned depth);
    return (a[WORD_SHIFT-1:0] != '0) || (a[ADDR_W-1:WORD_SHIFT] >= IDX_W'(depth));
  endfunction
endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 word storage, synchronous write and read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// Target side of the load/store path: one request at a time, LATENCY wait
// states, then a single-cycle ack carrying load data or err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] d_in,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] d_out,
  output logic              err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              wr_q, bad_q, rd_vld_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wd_q;

  logic              accept, bad_in, we, re;
  logic [AW-1:0]     idx_in, arr_idx;
  logic [DATA_W-1:0] arr_wdata, rdata;

  assign accept = req & ready;
  assign bad_in = addr_bad(address, DEPTH);
  assign idx_in = address[WORD_SHIFT +: AW];

  // With LATENCY=0 the array is hit on the accept edge, so use the live fields.
  assign arr_idx   = (state == IDLE) ? idx_in : idx_q;
  assign arr_wdata = (state == IDLE) ? d_in   : wd_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      bad_q    <= 1'b0;
      idx_q    <= '0;
      wd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        wr_q  <= write;
        bad_q <= bad_in;
        idx_q <= idx_in;
        wd_q  <= d_in;
      end
      if (re) rd_vld_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready    = 1'b0;
    ack      = 1'b0;
    we       = 1'b0;
    re       = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (bad_in) begin
            state_nx = RESP;
          end else if (LATENCY == 0) begin
            state_nx = RESP;
            we       = write;
            re       = ~write;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
          we       = wr_q;
          re       = ~wr_q;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RESP: begin
        ack      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign err = ack & bad_q;

  // Array read register has no reset; hide it until the first real load.
  assign d_out = rd_vld_q ? rdata : '0;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clock (clock),
    .we    (we),
    .re    (re),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (rdata)
  );
endmodule
